// File: rtl/prog_loader.sv
// Serial program loader: receives a UART 8N1 byte stream carrying a
// big-endian 16-bit word count followed by big-endian 32-bit words, and
// writes the words into instruction memory while holding the CPU in reset.
module prog_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  err
);

   localparam int              CNT_W   = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, DONE, ERR} ld_state_t;

   logic             rx_meta, rx_s;
   rx_state_t        rx_state, rx_next;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       rx_shift;
   logic             baud_done;
   logic             byte_valid, frame_err;

   ld_state_t             ld_state, ld_next;
   logic [7:0]            n_hi;
   logic [15:0]           hdr_word;
   logic                  hdr_too_big;
   logic [ADDR_WIDTH-1:0] last_idx;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            byte_cnt;
   logic [23:0]           word_buf;

   // Two-flop synchronizer for the asynchronous serial line, idling high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         // NOTE: non-blocking so the second flop takes the first flop's pre-edge value.
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Byte receiver state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_state <= R_IDLE;
      else      rx_state <= rx_next;
   end

   // Byte receiver next state: half a bit to the start midpoint, then full bits.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latch is inferred.
      rx_next   = rx_state;
      baud_done = (rx_state == R_START) ? (baud_cnt == HALF_M1) : (baud_cnt == FULL_M1);
      case (rx_state)
         R_IDLE:  if (!rx_s)     rx_next = R_START;
         R_START: if (baud_done) rx_next = rx_s ? R_IDLE : R_DATA;
         R_DATA:  if (baud_done && bit_cnt == 3'd7) rx_next = R_STOP;
         R_STOP:  if (baud_done) rx_next = R_IDLE;
         default: rx_next = R_IDLE;
      endcase
   end

   // Baud/bit counters, LSB-first shift register and the one-cycle byte strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (rx_state == R_IDLE || baud_done) baud_cnt <= '0;
         else                                 baud_cnt <= baud_cnt + 1'b1;
         if (rx_state == R_IDLE) bit_cnt <= '0;
         if (rx_state == R_DATA && baud_done) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
         end
         if (rx_state == R_STOP && baud_done) begin
            byte_valid <= rx_s;
            frame_err  <= !rx_s;
         end
      end
   end

   assign hdr_word    = {n_hi, rx_shift};
   assign hdr_too_big = (hdr_word >> ADDR_WIDTH) != 16'd0;

   // Load FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ld_state <= HDR_HI;
      else      ld_state <= ld_next;
   end

   // Load FSM next state: header, data words, then a terminal DONE or ERR.
   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         HDR_HI: begin
            if (frame_err)       ld_next = ERR;
            else if (byte_valid) ld_next = HDR_LO;
         end
         HDR_LO: begin
            if (frame_err)                ld_next = ERR;
            else if (byte_valid) begin
               if (hdr_too_big)           ld_next = ERR;
               else if (hdr_word == 16'd0) ld_next = DONE;
               else                       ld_next = DATA;
            end
         end
         DATA: begin
            if (frame_err)                              ld_next = ERR;
            else if (imem_we && imem_addr == last_idx)  ld_next = DONE;
         end
         default: ld_next = ld_state;
      endcase
   end

   // Header capture, big-endian word assembly and the single-cycle write strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_hi       <= '0;
         last_idx   <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         word_buf   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (byte_valid) begin
            case (ld_state)
               HDR_HI: n_hi <= rx_shift;
               HDR_LO: begin
                  last_idx <= ADDR_WIDTH'(hdr_word - 16'd1);
                  word_idx <= '0;
                  byte_cnt <= '0;
               end
               DATA: begin
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_wdata <= {word_buf, rx_shift};
                     imem_addr  <= word_idx;
                     word_idx   <= word_idx + 1'b1;
                  end else begin
                     word_buf <= {word_buf[15:0], rx_shift};
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign cpu_hold = (ld_state != DONE);
   assign done     = (ld_state == DONE);
   assign err      = (ld_state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed loads plus random loads, each checked
// against a byte-stream reference model of the loader protocol.
module tb_prog_loader;

   localparam int CPB = 4;
   localparam int AW  = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx  = 1'b1;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold, done, err;

   int n_pass   = 0;
   int n_checks = 0;

   logic [7:0]       tx_bytes[$];
   int               bad_idx;
   logic [AW+31:0]   wr_log[$];
   logic [AW+31:0]   exp_log[$];
   logic             exp_done, exp_err;

   prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Record every cycle the write strobe is high, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst && imem_we) wr_log.push_back({imem_addr, imem_wdata});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB + $urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic send_all();
      for (int i = 0; i < tx_bytes.size(); i++) send_byte(tx_bytes[i], i != bad_idx);
      repeat (20) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wr_log.delete();
   endtask

   // Reference: walk the byte stream as header count plus 4-byte big-endian words.
   task automatic build_model();
      int          k = 0;
      int          n = 0;
      logic [31:0] w = '0;
      exp_log.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      for (int i = 0; i < tx_bytes.size(); i++) begin
         if (exp_done || exp_err) continue;
         if (i == bad_idx) begin
            exp_err = 1'b1;
            continue;
         end
         if (k == 0) n = int'(tx_bytes[i]) * 256;
         else if (k == 1) begin
            n = n + int'(tx_bytes[i]);
            if (n >= (1 << AW)) exp_err = 1'b1;
            else if (n == 0)    exp_done = 1'b1;
         end else begin
            w = {w[23:0], tx_bytes[i]};
            if ((k - 2) % 4 == 3) begin
               exp_log.push_back({AW'((k - 2) / 4), w});
               if ((k - 2) / 4 == n - 1) exp_done = 1'b1;
            end
         end
         k++;
      end
   endtask

   task automatic check_result(input string name);
      build_model();
      check({name, "_nwr"}, 64'(wr_log.size()), 64'(exp_log.size()));
      for (int i = 0; i < exp_log.size(); i++)
         check($sformatf("%s_wr%0d", name, i), 64'(wr_log[i]), 64'(exp_log[i]));
      check({name, "_done"}, 64'(done), 64'(exp_done));
      check({name, "_err"}, 64'(err), 64'(exp_err));
      check({name, "_hold"}, 64'(cpu_hold), 64'(!exp_done));
      if (exp_log.size() > 0)
         check({name, "_held"}, 64'({imem_addr, imem_wdata}), 64'(exp_log[exp_log.size()-1]));
   endtask

   initial begin
      bad_idx = -1;
      repeat (3) @(negedge clk);
      check("rst_we",    64'(imem_we),    64'(0));
      check("rst_addr",  64'(imem_addr),  64'(0));
      check("rst_wdata", 64'(imem_wdata), 64'(0));
      check("rst_hold",  64'(cpu_hold),   64'(1));
      check("rst_done",  64'(done),       64'(0));
      check("rst_err",   64'(err),        64'(0));
      rst = 1'b1;
      wr_log.delete();

      // Two-word load.
      tx_bytes = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
      bad_idx  = -1;
      send_all();
      check_result("two_words");
      check("two_words_w0", 64'(wr_log[0]), 64'({12'd0, 32'hDEADBEEF}));
      check("two_words_w1", 64'(wr_log[1]), 64'({12'd1, 32'h12345678}));

      // Asynchronous reset between clock edges clears outputs at once.
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_addr",  64'(imem_addr),  64'(0));
      check("arst_wdata", 64'(imem_wdata), 64'(0));
      check("arst_hold",  64'(cpu_hold),   64'(1));
      check("arst_done",  64'(done),       64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wr_log.delete();

      // Zero-length header, trailing bytes ignored.
      tx_bytes = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      send_all();
      check_result("empty");

      // Header exceeding the address range.
      do_reset();
      tx_bytes = '{8'h10, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_all();
      check_result("too_big");

      // Framing error mid-word.
      do_reset();
      tx_bytes = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h02, 8'h03, 8'h04};
      bad_idx  = 4;
      send_all();
      check_result("frame_err");
      bad_idx = -1;

      // One-cycle glitch on the line before a valid load.
      do_reset();
      @(negedge clk) rx = 1'b0;
      @(negedge clk) rx = 1'b1;
      repeat (10) @(negedge clk);
      tx_bytes = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
      send_all();
      check_result("glitch");
      check("glitch_w0", 64'(wr_log[0]), 64'({12'd0, 32'h01020304}));

      // Reset in the middle of the first word discards the partial data.
      do_reset();
      tx_bytes = '{8'h00, 8'h01, 8'h11, 8'h22};
      send_all();
      check("partial_nwr",  64'(wr_log.size()), 64'(0));
      check("partial_hold", 64'(cpu_hold),      64'(1));
      do_reset();
      tx_bytes = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
      send_all();
      check_result("restart");
      check("restart_w0", 64'(wr_log[0]), 64'({12'd0, 32'hCAFEF00D}));

      // Random loads, sometimes oversized or with a bad stop bit, plus trailing junk.
      for (int it = 0; it < 6; it++) begin
         int n;
         int nd;
         do_reset();
         tx_bytes.delete();
         n = (it == 3) ? int'($urandom_range(4096, 65535)) : int'($urandom_range(1, 5));
         tx_bytes.push_back(8'(n >> 8));
         tx_bytes.push_back(8'(n));
         nd = (n > 5) ? 8 : 4 * n;
         for (int j = 0; j < nd; j++) tx_bytes.push_back(8'($urandom));
         bad_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tx_bytes.size() - 1)) : -1;
         for (int j = 0; j < int'($urandom_range(0, 4)); j++) tx_bytes.push_back(8'($urandom));
         send_all();
         check_result($sformatf("rand%0d", it));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
